// File: rtl/decoder_2to4_strobe_if.sv
// Code/strobe bundle between the encoded-command source and the 2-to-4 strobe decoder.
// master = command source and counter reader, slave = decoder.
interface decoder_2to4_strobe_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [1:0]       in_code;
  logic             in_en;
  logic             in_ready;
  logic [3:0]       o;
  logic             busy;
  logic             done;
  logic [1:0]       cnt_sel;
  logic [CNT_W-1:0] cnt_out;

  modport master (
    output in_valid, in_code, in_en, cnt_sel,
    input  in_ready, o, busy, done, cnt_out
  );

  modport slave (
    input  in_valid, in_code, in_en, cnt_sel,
    output in_ready, o, busy, done, cnt_out
  );
endinterface

// File: rtl/decoder_2to4_strobe.sv
// Registered 2-to-4 decoder: holds a one-hot strobe for PULSE_W (>=1) cycles, then one all-zero
// gap cycle with done; ready only in IDLE, so codes arriving while busy stall at the source.
module decoder_2to4_strobe #(
  parameter int PULSE_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  decoder_2to4_strobe_if.slave bus
);
  localparam int               PCW       = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [PCW-1:0]   PCNT_LOAD = PCW'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] HIT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [PCW-1:0]   pcnt, pcnt_nxt;
  logic [1:0]       code_q, code_nxt;
  logic             en_q, en_nxt;
  logic [3:0]       o_q, o_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic [CNT_W-1:0] hit [4];
  logic             accept;

  assign bus.in_ready = (state == IDLE) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    code_nxt  = code_q;
    en_nxt    = en_q;
    case (state)
      IDLE: begin
        if (accept) begin
          code_nxt  = bus.in_code;
          en_nxt    = bus.in_en;
          pcnt_nxt  = PCNT_LOAD;
          state_nxt = bus.in_en ? PULSE : GAP;
        end
      end
      PULSE: begin
        if (pcnt == '0) begin
          state_nxt = GAP;
        end else begin
          pcnt_nxt = pcnt - PCW'(1);
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered from the next state so the strobe lines come straight off flops.
    o_nxt    = (state_nxt == PULSE && en_nxt) ? (4'b0001 << code_nxt) : 4'b0000;
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == GAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pcnt   <= '0;
      code_q <= '0;
      en_q   <= 1'b0;
      o_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        hit[i] <= '0;
      end
    end else begin
      state  <= state_nxt;
      pcnt   <= pcnt_nxt;
      code_q <= code_nxt;
      en_q   <= en_nxt;
      o_q    <= o_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      // Saturate rather than wrap so a stuck-on source reads as "many", never as "few".
      if (accept && bus.in_en && (hit[bus.in_code] != HIT_MAX)) begin
        hit[bus.in_code] <= hit[bus.in_code] + CNT_W'(1);
      end
    end
  end

  assign bus.o       = o_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.cnt_out = hit[bus.cnt_sel];
endmodule

// File: tb/tb_decoder_2to4_strobe.sv
// Bench for decoder_2to4_strobe: instance A (PULSE_W=4, CNT_W=8), instance B (PULSE_W=1, CNT_W=2),
// an event-time model of each, a per-cycle compare process and directed literal checks.
module tb_decoder_2to4_strobe;
  localparam int PW_A = 4, CW_A = 8;
  localparam int PW_B = 1, CW_B = 2;

  logic clk;
  logic rst;

  decoder_2to4_strobe_if #(.CNT_W(CW_A)) ifa ();
  decoder_2to4_strobe_if #(.CNT_W(CW_B)) ifb ();

  decoder_2to4_strobe #(.PULSE_W(PW_A), .CNT_W(CW_A)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  decoder_2to4_strobe #(.PULSE_W(PW_B), .CNT_W(CW_B)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model: each transaction is described by its accept edge, code and enable only.
  int m_t    [2];
  int m_free [2];
  int m_code [2];
  bit m_en   [2];
  int m_hit  [2][4];

  function automatic int pw(input int i);
    return (i == 0) ? PW_A : PW_B;
  endfunction

  function automatic int cmax(input int i);
    return (i == 0) ? ((1 << CW_A) - 1) : ((1 << CW_B) - 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] d_o(input int i);    return (i == 0) ? 32'(ifa.o) : 32'(ifb.o); endfunction
  function automatic logic [31:0] d_busy(input int i); return (i == 0) ? 32'(ifa.busy) : 32'(ifb.busy); endfunction
  function automatic logic [31:0] d_done(input int i); return (i == 0) ? 32'(ifa.done) : 32'(ifb.done); endfunction
  function automatic logic [31:0] d_rdy(input int i);  return (i == 0) ? 32'(ifa.in_ready) : 32'(ifb.in_ready); endfunction
  function automatic logic [31:0] d_cnt(input int i);  return (i == 0) ? 32'(ifa.cnt_out) : 32'(ifb.cnt_out); endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_t[i] = -1000; m_free[i] = 0; m_code[i] = 0; m_en[i] = 1'b0;
      for (int k = 0; k < 4; k++) m_hit[i][k] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        bit v, en;
        int code;
        v    = (i == 0) ? ifa.in_valid : ifb.in_valid;
        en   = (i == 0) ? ifa.in_en : ifb.in_en;
        code = (i == 0) ? int'(ifa.in_code) : int'(ifb.in_code);
        if (rst) begin
          m_t[i] = -1000; m_free[i] = 0; m_en[i] = 1'b0;
          for (int k = 0; k < 4; k++) m_hit[i][k] = 0;
        end else if (v && (cyc - 1 >= m_free[i])) begin
          m_t[i] = cyc; m_code[i] = code; m_en[i] = en;
          m_free[i] = en ? cyc + pw(i) + 1 : cyc + 1;
          if (en && m_hit[i][code] < cmax(i)) m_hit[i][code]++;
        end
      end
    end
  end

  // Compare process: every cycle after the first edge, both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        for (int i = 0; i < 2; i++) begin
          int eo, sel;
          string nm;
          nm  = (i == 0) ? "A" : "B";
          eo  = (m_en[i] && cyc >= m_t[i] && cyc <= m_t[i] + pw(i) - 1) ? (1 << m_code[i]) : 0;
          sel = (i == 0) ? int'(ifa.cnt_sel) : int'(ifb.cnt_sel);
          chk({nm, ".o"}, d_o(i), 32'(eo));
          chk({nm, ".done"}, d_done(i), 32'(cyc == m_t[i] + (m_en[i] ? pw(i) : 0)));
          chk({nm, ".busy"}, d_busy(i), 32'(cyc >= m_t[i] && cyc < m_free[i]));
          chk({nm, ".in_ready"}, d_rdy(i), 32'(!rst && cyc >= m_free[i]));
          chk({nm, ".cnt_out"}, d_cnt(i), 32'(m_hit[i][sel]));
        end
      end
    end
  end

  task automatic drive(input int i, input bit v, input int code, input bit en);
    if (i == 0) begin ifa.in_valid = v; ifa.in_code = 2'(code); ifa.in_en = en; end
    else        begin ifb.in_valid = v; ifb.in_code = 2'(code); ifb.in_en = en; end
  endtask

  // Present a code and wait for its accept edge; returns #1 after that edge with t = edge index.
  task automatic send(input int i, input int code, input bit en, output int t);
    drive(i, 1'b1, code, en);
    t = -1;
    for (int n = 0; n < 40; n++) begin
      if (d_rdy(i) == 32'd1) begin
        @(posedge clk);
        #1;
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: instance %0d code %0d never accepted, required within 40 cycles", i, code);
    end
  endtask

  task automatic at_cycle(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  int t0, t1, t2;
  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 0, 1'b0);
    drive(1, 1'b0, 0, 1'b0);
    ifa.cnt_sel = 2'd0;
    ifb.cnt_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_o", d_o(0), 32'd0);
    chk("reset_cnt", d_cnt(0), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", d_rdy(0), 32'd1);

    // Single code 2 strobe on A.
    send(0, 2, 1'b1, t0);
    drive(0, 1'b0, 0, 1'b0);
    at_cycle(t0);
    chk("single_o_first", d_o(0), 32'h4);
    at_cycle(t0 + 3);
    chk("single_o_last", d_o(0), 32'h4);
    at_cycle(t0 + 4);
    chk("single_gap_o", d_o(0), 32'h0);
    chk("single_done", d_done(0), 32'd1);
    at_cycle(t0 + 5);
    chk("single_ready_back", d_rdy(0), 32'd1);
    ifa.cnt_sel = 2'd2;
    #1;
    chk("single_hit2", d_cnt(0), 32'd1);
    chk("model_hit2", 32'(m_hit[0][2]), 32'd1);

    // Back-to-back 0,1,3 with in_valid held.
    send(0, 0, 1'b1, t0);
    send(0, 1, 1'b1, t1);
    send(0, 3, 1'b1, t2);
    drive(0, 1'b0, 0, 1'b0);
    chk("b2b_spacing01", 32'(t1 - t0), 32'd6);
    chk("b2b_spacing13", 32'(t2 - t1), 32'd6);
    at_cycle(t2);
    chk("b2b_o3", d_o(0), 32'h8);
    at_cycle(t2 + 6);
    for (int s = 0; s < 4; s++) begin
      ifa.cnt_sel = 2'(s);
      #1;
      chk("b2b_hits", d_cnt(0), 32'd1);
    end

    // Code 3 with enable low: consumed, no strobe, no count.
    send(0, 3, 1'b0, t0);
    drive(0, 1'b0, 0, 1'b0);
    at_cycle(t0);
    chk("noen_o", d_o(0), 32'h0);
    chk("noen_done", d_done(0), 32'd1);
    at_cycle(t0 + 1);
    chk("noen_ready", d_rdy(0), 32'd1);
    ifa.cnt_sel = 2'd3;
    #1;
    chk("noen_hit3", d_cnt(0), 32'd1);

    // Reset two cycles into a code-1 strobe, with a code presented while reset is held.
    send(0, 1, 1'b1, t0);
    drive(0, 1'b0, 0, 1'b0);
    at_cycle(t0 + 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 1'b1, 2, 1'b1);
    chk("rst_o", d_o(0), 32'h0);
    chk("rst_busy", d_busy(0), 32'd0);
    chk("rst_done", d_done(0), 32'd0);
    chk("rst_ready_low", d_rdy(0), 32'd0);
    for (int s = 0; s < 4; s++) begin
      ifa.cnt_sel = 2'(s);
      #1;
      chk("rst_cnt_clear", d_cnt(0), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 1'b0, 0, 1'b0);
    ifa.cnt_sel = 2'd2;
    #1;
    chk("rst_ready_back", d_rdy(0), 32'd1);
    chk("rst_accept_dropped", d_cnt(0), 32'd0);

    // Saturation on B (CNT_W=2).
    ifb.cnt_sel = 2'd0;
    for (int k = 0; k < 5; k++) begin
      send(1, 0, 1'b1, t0);
      drive(1, 1'b0, 0, 1'b0);
      at_cycle(t0);
      chk("sat_cnt", d_cnt(1), 32'(sat_exp[k]));
    end

    // PULSE_W=1 on B.
    send(1, 1, 1'b1, t0);
    drive(1, 1'b0, 0, 1'b0);
    at_cycle(t0);
    chk("pw1_o", d_o(1), 32'h2);
    at_cycle(t0 + 1);
    chk("pw1_gap_o", d_o(1), 32'h0);
    chk("pw1_done", d_done(1), 32'd1);
    at_cycle(t0 + 2);
    chk("pw1_ready", d_rdy(1), 32'd1);
    send(1, 1, 1'b1, t1);
    send(1, 2, 1'b1, t2);
    drive(1, 1'b0, 0, 1'b0);
    chk("pw1_spacing", 32'(t2 - t1), 32'd3);
    chk("model_b_hit0", 32'(m_hit[1][0]), 32'd3);

    repeat (5) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required to finish earlier");
    $fatal(1);
  end
endmodule
